// File: rtl/im_bus_pkg.sv
// im_bus_pkg: response codes and response-FIFO entry layout for the IM read bus.
// The entry struct is sized by IM_DLEN/IM_ILEN; responder DLEN/ILEN must match them.
package im_bus_pkg;
   localparam int IM_DLEN = 32;
   localparam int IM_ILEN = 4;
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_t;
   typedef struct packed {
      logic [IM_DLEN-1:0] data;
      logic [IM_ILEN-1:0] id;
      resp_t              resp;
   } rd_entry_t;
endpackage

// File: rtl/im_bus_read_responder_if.sv
// im_bus_read_responder_if: AXI5-Lite read-only AR/R channel bundle with master/slave views.
interface im_bus_read_responder_if #(
   parameter int ALEN = 32,
   parameter int DLEN = 32,
   parameter int ILEN = 4
);
   logic            arvalid;
   logic            arready;
   logic [ALEN-1:0] araddr;
   logic [2:0]      arprot;
   logic [ILEN-1:0] arid;
   logic            rvalid;
   logic            rready;
   logic [DLEN-1:0] rdata;
   logic [1:0]      rresp;
   logic [ILEN-1:0] rid;
   modport slave (input arvalid, araddr, arprot, arid, rready,
                  output arready, rvalid, rdata, rresp, rid);
   modport master (output arvalid, araddr, arprot, arid, rready,
                   input arready, rvalid, rdata, rresp, rid);
endinterface

// File: rtl/im_bus_resp_fifo.sv
// im_bus_resp_fifo: synchronous FIFO with wrap-bit pointers; full/empty come from the extra MSB.
module im_bus_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 38,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty,
   output logic [AW:0]  o_count
);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end
   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_count = r_wptr - r_rptr;
   assign o_empty = r_wptr == r_rptr;
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   // Credit accounting upstream makes these unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(i_push && o_full));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(i_pop && o_empty));
endmodule

// File: rtl/im_bus_read_responder.sv
// im_bus_read_responder: IM AXI5-Lite read responder; SRAM read, pending stage, in-order R FIFO.
// Optional IM_BUS_PROT_CHECK_EN answers data-side (arprot[2]==0) requests with SLVERR.
module im_bus_read_responder
   import im_bus_pkg::*;
#(
   parameter int ALEN = 32,
   parameter int DLEN = IM_DLEN,
   parameter int ILEN = IM_ILEN,
   parameter int MEM_AW = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   im_bus_read_responder_if.slave  im_bus,
   output logic                    o_mem_en,
   output logic [MEM_AW-1:0]       o_mem_addr,
   input  logic [DLEN-1:0]         i_mem_rdata
);
   localparam int FAW = $clog2(FIFO_DEPTH);
   logic            r_pend_valid;
   logic [ILEN-1:0] r_pend_id;
   resp_t           r_pend_resp;
   logic            w_decerr;
   logic            w_misalign;
   logic            w_prot_err;
   resp_t           w_resp;
   logic            w_ar_hs;
   logic [FAW:0]    w_count;
   logic [FAW+1:0]  w_used;
   logic            w_full;
   logic            w_empty;
   logic            w_rvalid;
   rd_entry_t       w_wentry;
   rd_entry_t       w_head;
   logic            w_unused;
   assign w_decerr   = |im_bus.araddr[ALEN-1:MEM_AW+2];
   assign w_misalign = |im_bus.araddr[1:0];
`ifdef IM_BUS_PROT_CHECK_EN
   assign w_prot_err = ~im_bus.arprot[2];
`else
   assign w_prot_err = 1'b0;
`endif
   assign w_unused = ^{im_bus.arprot, w_full};
   always_comb begin
      w_resp = w_decerr ? RESP_DECERR :
               (w_misalign || w_prot_err) ? RESP_SLVERR : RESP_OKAY;
   end
   // Credits count both queued beats and the one still in the SRAM stage.
   assign w_used          = {1'b0, w_count} + {{(FAW+1){1'b0}}, r_pend_valid};
   assign im_bus.arready  = rstn && (w_used < (FAW+2)'(FIFO_DEPTH));
   assign w_ar_hs         = im_bus.arvalid && im_bus.arready;
   assign o_mem_en        = w_ar_hs && (w_resp == RESP_OKAY);
   assign o_mem_addr      = im_bus.araddr[MEM_AW+1:2];
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend_valid <= 1'b0;
         r_pend_id    <= '0;
         r_pend_resp  <= RESP_OKAY;
      end else begin
         r_pend_valid <= w_ar_hs;
         if (w_ar_hs) begin
            r_pend_id   <= im_bus.arid;
            r_pend_resp <= w_resp;
         end
      end
   end
   always_comb begin
      w_wentry.data = (r_pend_resp == RESP_OKAY) ? i_mem_rdata : '0;
      w_wentry.id   = r_pend_id;
      w_wentry.resp = r_pend_resp;
   end
   im_bus_resp_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(rd_entry_t))) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (r_pend_valid),
      .i_wdata (w_wentry),
      .i_pop   (w_rvalid && im_bus.rready),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign w_rvalid     = !w_empty;
   assign im_bus.rvalid = w_rvalid;
   assign im_bus.rdata  = w_rvalid ? w_head.data : '0;
   assign im_bus.rresp  = w_rvalid ? w_head.resp : RESP_OKAY;
   assign im_bus.rid    = w_rvalid ? w_head.id : '0;
endmodule

// File: tb/tb_im_bus_read_responder.sv
// tb_im_bus_read_responder: table-driven single reads plus streaming, backpressure and reset sequences.
module tb_im_bus_read_responder;
   import im_bus_pkg::*;
   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [2:0]  prot;
      logic        en;
      logic [1:0]  resp;
      logic [31:0] data;
   } vec_t;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] sram [1024];
   vec_t        tbl [8];
   vec_t        st [16];
   int          total = 0;
   int          bad = 0;
   always #5 clk = ~clk;
   im_bus_read_responder_if #(.ALEN(32), .DLEN(32), .ILEN(4)) bus ();
   im_bus_read_responder #(.ALEN(32), .DLEN(32), .ILEN(4), .MEM_AW(10), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .im_bus      (bus),
      .o_mem_en    (mem_en),
      .o_mem_addr  (mem_addr),
      .i_mem_rdata (mem_rdata)
   );
   function automatic logic [31:0] word(input int k);
      return (k == 4) ? 32'hDEAD_BEEF : {16'hC0DE, 16'(k)};
   endfunction
   always @(posedge clk) if (mem_en) mem_rdata <= sram[mem_addr];
   function automatic vec_t mk(input logic [31:0] a, input logic [3:0] id, input logic [2:0] p,
                               input logic en, input logic [1:0] r, input logic [31:0] d);
      vec_t v;
      v.addr = a; v.id = id; v.prot = p; v.en = en; v.resp = r; v.data = d;
      return v;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask
   // Drives st[0..n-1] back to back with rready=1 and checks mem side, latency and R beats.
   task automatic run_stream(input int n, input string tag);
      int nb = 0;
      for (int c = 0; c < n + 4; c++) begin
         @(posedge clk); #1;
         bus.arvalid = (c < n);
         if (c < n) begin
            bus.araddr = st[c].addr;
            bus.arid   = st[c].id;
            bus.arprot = st[c].prot;
         end
         @(negedge clk);
         if (c < n) begin
            chk({tag, " arready"}, 32'(bus.arready), 32'd1);
            chk({tag, " mem_en"}, 32'(mem_en), 32'(st[c].en));
            if (st[c].en) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(st[c].addr[11:2]));
         end
         chk({tag, " rvalid"}, 32'(bus.rvalid), 32'(c >= 2 && c < n + 2));
         if (bus.rvalid && nb < n) begin
            chk({tag, " rdata"}, bus.rdata, st[nb].data);
            chk({tag, " rresp"}, 32'(bus.rresp), 32'(st[nb].resp));
            chk({tag, " rid"}, 32'(bus.rid), 32'(st[nb].id));
            nb++;
         end
      end
      chk({tag, " beats"}, 32'(nb), 32'(n));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int acc;
      bit seen;
      logic [31:0] hd;
      logic [3:0] hid;
      for (int k = 0; k < 1024; k++) sram[k] = word(k);
      mem_rdata = '0;
      bus.arvalid = 1'b1;
      bus.araddr = 32'h10;
      bus.arprot = 3'b100;
      bus.arid = 4'd3;
      bus.rready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst arready", 32'(bus.arready), 0);
      chk("rst rvalid", 32'(bus.rvalid), 0);
      chk("rst rdata", bus.rdata, 0);
      chk("rst rresp", 32'(bus.rresp), 0);
      chk("rst rid", 32'(bus.rid), 0);
      chk("rst mem_en", 32'(mem_en), 0);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      rstn = 1'b1;
      tbl[0] = mk(32'h0000_0010, 4'd3, 3'b100, 1'b1, RESP_OKAY, 32'hDEAD_BEEF);
      tbl[1] = mk(32'h0000_1000, 4'd5, 3'b100, 1'b0, RESP_DECERR, 32'h0);
      tbl[2] = mk(32'h0000_0006, 4'd6, 3'b100, 1'b0, RESP_SLVERR, 32'h0);
      tbl[3] = mk(32'h0000_0FFC, 4'd7, 3'b100, 1'b1, RESP_OKAY, 32'hC0DE_03FF);
`ifdef IM_BUS_PROT_CHECK_EN
      tbl[4] = mk(32'h0000_0008, 4'd9, 3'b000, 1'b0, RESP_SLVERR, 32'h0);
`else
      tbl[4] = mk(32'h0000_0008, 4'd9, 3'b000, 1'b1, RESP_OKAY, 32'hC0DE_0002);
`endif
      tbl[5] = mk(32'h8000_0000, 4'd1, 3'b100, 1'b0, RESP_DECERR, 32'h0);
      tbl[6] = mk(32'h0000_1003, 4'd2, 3'b100, 1'b0, RESP_DECERR, 32'h0);
      tbl[7] = mk(32'h0000_0001, 4'd4, 3'b100, 1'b0, RESP_SLVERR, 32'h0);
      for (int i = 0; i < 8; i++) begin
         st[0] = tbl[i];
         run_stream(1, $sformatf("vec%0d", i));
      end
      for (int i = 0; i < 8; i++) st[i] = mk(32'(i * 4), 4'(i), 3'b100, 1'b1, RESP_OKAY, word(i));
      run_stream(8, "b2b");
      st[0] = mk(32'h0000_000C, 4'd1, 3'b100, 1'b1, RESP_OKAY, 32'hC0DE_0003);
      st[1] = mk(32'h0000_1000, 4'd2, 3'b100, 1'b0, RESP_DECERR, 32'h0);
      st[2] = mk(32'h0000_0014, 4'd3, 3'b100, 1'b1, RESP_OKAY, 32'hC0DE_0005);
      st[3] = mk(32'h0000_0006, 4'd4, 3'b100, 1'b0, RESP_SLVERR, 32'h0);
      run_stream(4, "mix");
      // Backpressure: only FIFO_DEPTH requests may be accepted, head must hold.
      acc = 0;
      seen = 0;
      hd = '0;
      hid = '0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         bus.rready = 1'b0;
         bus.arvalid = 1'b1;
         bus.araddr = 32'((8 + acc) * 4);
         bus.arid = 4'(8 + acc);
         bus.arprot = 3'b100;
         @(negedge clk);
         if (bus.arready) acc++;
         else chk("bp mem_en", 32'(mem_en), 0);
         if (bus.rvalid) begin
            if (!seen) begin
               seen = 1;
               hd = bus.rdata;
               hid = bus.rid;
               chk("bp head data", bus.rdata, word(8));
               chk("bp head rid", 32'(bus.rid), 32'd8);
            end else begin
               chk("bp hold data", bus.rdata, hd);
               chk("bp hold rid", 32'(bus.rid), 32'(hid));
            end
         end
      end
      chk("bp accepted", 32'(acc), 32'd4);
      chk("bp arready low", 32'(bus.arready), 0);
      for (int d = 0; d < 5; d++) begin
         @(posedge clk); #1;
         bus.arvalid = 1'b0;
         bus.rready = 1'b1;
         @(negedge clk);
         chk($sformatf("drain%0d arready", d), 32'(bus.arready), 32'(d >= 1));
         chk($sformatf("drain%0d rvalid", d), 32'(bus.rvalid), 32'(d < 4));
         if (d < 4) begin
            chk($sformatf("drain%0d rdata", d), bus.rdata, word(8 + d));
            chk($sformatf("drain%0d rid", d), 32'(bus.rid), 32'(8 + d));
         end
      end
      // Reset with three beats queued must discard them.
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         bus.rready = 1'b0;
         bus.arvalid = (c < 3);
         bus.araddr = 32'(c * 4);
         bus.arid = 4'(c);
         @(negedge clk);
         if (c < 3) chk("rq arready", 32'(bus.arready), 1);
      end
      chk("rq queued rvalid", 32'(bus.rvalid), 1);
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      chk("rq rst rvalid", 32'(bus.rvalid), 0);
      chk("rq rst arready", 32'(bus.arready), 0);
      chk("rq rst rdata", bus.rdata, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      bus.rready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rq post rvalid", 32'(bus.rvalid), 0);
         chk("rq post arready", 32'(bus.arready), 1);
      end
      st[0] = tbl[0];
      run_stream(1, "post_rst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
